tt_extract: RTL and testbench
=============================

TT_EXTRACT -- requirements
Module: tt_extract

Interface
REQ-001 Parameter SETTLE, default 4: clock cycles each input combination is held before its output is sampled; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request one full characterisation sweep; sampled only in IDLE.
REQ-005 abort  input  1  cancel sweep in progress.
REQ-006 expect_code  input  8  expected truth-table byte, sampled at start acceptance.
REQ-007 dut_out  input  1  logic-gate output under test, asynchronous to clk.
REQ-008 dut_in  output  3  applied combination {in1,in2,in3}, in1 = bit 2.
REQ-009 busy  output  1  high from start acceptance until the cycle before done.
REQ-010 done  output  1  one-cycle pulse: sweep complete, tt_code/match valid.
REQ-011 tt_code  output  8  captured truth-table byte.
REQ-012 match  output  1  tt_code equals latched expect_code.

Function
REQ-013 The block SHALL implement states IDLE, APPLY, SAMPLE, DONE.
REQ-014 IDLE: start=1 SHALL latch expect_code, clear idx to 0, set dut_in=0, busy=1, and enter APPLY next cycle.
REQ-015 APPLY SHALL hold dut_in=idx for exactly SETTLE cycles, then enter SAMPLE.
REQ-016 SAMPLE SHALL write the synchronised dut_out into tt_code bit (7 - idx), so combination 000 maps to the MSB.
REQ-017 From SAMPLE: idx<7 SHALL increment idx, update dut_in, and return to APPLY; idx=7 SHALL enter DONE.
REQ-018 DONE SHALL assert done for one cycle, drop busy, register match, and return to IDLE.
REQ-019 Start acceptance to done pulse SHALL be 8*(SETTLE+1)+1 cycles.
REQ-020 tt_code bits SHALL update only in SAMPLE.
REQ-021 tt_code and match SHALL hold their values from DONE until the next start acceptance.
REQ-022 At start acceptance match SHALL clear to 0.
REQ-023 start while busy SHALL be ignored.
REQ-024 start coincident with done SHALL be ignored; a new sweep needs start in IDLE.
REQ-025 abort in any non-IDLE state SHALL return to IDLE next cycle with busy=0, no done pulse, dut_in=0, and tt_code/match at their pre-sweep values.
REQ-026 abort has priority over all other transitions.
REQ-027 abort in IDLE SHALL have no effect; abort and start together in IDLE SHALL leave the block in IDLE.
REQ-028 dut_out SHALL pass through a 2-flop synchroniser before sampling.
REQ-029 SETTLE >= 2 SHALL cover the synchroniser latency.

Reset
REQ-030 rst_n low SHALL force IDLE, dut_in=0, busy=0, done=0, tt_code=0x00, match=0, idx=0, settle counter=0, synchroniser flops=0, independent of clk.
REQ-031 Reset release SHALL take effect on the next clk edge.
REQ-032 Reset asserted mid-sweep SHALL discard all partial results.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE/APPLY/SAMPLE/DONE), N_INPUTS=3, N_COMBOS=8, and CODE_W=8.
REQ-034 The synchroniser SHALL be a sub-module, sync2 (1-bit, clk, rst_n), instantiated once.
REQ-035 The settle counter width SHALL be 8 bits.

Verification
REQ-036 Sweep test: dut_out modelled as NOT(in1 AND (in2 OR in3)) with SETTLE=4, expect_code=0xF8 -> done at cycle 41 after acceptance, tt_code=0xF8, match=1.
REQ-037 Constant and mismatch test: dut_out tied 0, expect_code=0xFF -> tt_code=0x00, match=0.
REQ-038 Abort test: abort during idx=3 APPLY -> IDLE next cycle, no done pulse, tt_code unchanged from prior sweep.
REQ-039 Start-while-busy test: start pulses while busy -> exactly one done, latency unchanged.
REQ-040 Reset test: rst_n low mid-SAMPLE, asynchronous to clk -> all outputs 0 immediately.
REQ-041 Back-to-back sweeps: start the cycle after done -> second sweep correct.
REQ-042 Sweep-order check: dut_in SHALL step 0..7 with each value held SETTLE+1 cycles.

Source files
------------

// File: rtl/tt_extract_pkg.sv
// Shared types and sizes for the gate truth-table extractor.
package tt_extract_pkg;

  localparam int N_INPUTS = 3;
  localparam int N_COMBOS = 8;
  localparam int CODE_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/tt_extract_if.sv
// Control, stimulus and result signals between the extractor and its user.
interface tt_extract_if;

  logic                               start;
  logic                               abort;
  logic [tt_extract_pkg::CODE_W-1:0]   expect_code;
  logic                               dut_out;
  logic [tt_extract_pkg::N_INPUTS-1:0] dut_in;
  logic                               busy;
  logic                               done;
  logic [tt_extract_pkg::CODE_W-1:0]   tt_code;
  logic                               match;

  modport slave (
    input  start, abort, expect_code, dut_out,
    output dut_in, busy, done, tt_code, match
  );

  modport master (
    output start, abort, expect_code, dut_out,
    input  dut_in, busy, done, tt_code, match
  );

endinterface

// File: rtl/tt_extract_sync2.sv
// Two-flop synchroniser for the asynchronous gate output.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // meta is the only flop allowed to go metastable; q is its resolved copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tt_extract.sv
// Truth-table extractor: sweeps all 3-input combinations onto a logic gate,
// waits for it to settle, and packs the gate response into one byte.
//
// state  | meaning
// IDLE   | waiting for start; results from the last sweep held
// APPLY  | dut_in = idx held while the settle counter runs down
// SAMPLE | synchronised gate output written to tt_code[7-idx]
// DONE   | compare against expect_code, pulse done, drop busy
module tt_extract
  import tt_extract_pkg::*;
#(
  parameter int unsigned SETTLE = 4
) (
  input logic        clk,
  input logic        rst_n,
  tt_extract_if.slave bus
);

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE - 1);
  localparam logic [N_INPUTS-1:0] IDX_LAST = N_INPUTS'(N_COMBOS - 1);

  state_t state, state_nxt;

  logic [N_INPUTS-1:0] idx;
  logic [7:0]          cnt;
  logic [N_INPUTS-1:0] dut_in_q;
  logic                busy_q;
  logic                done_q;
  logic [CODE_W-1:0]   tt_code_q;
  logic                match_q;
  logic [CODE_W-1:0]   exp_q;
  // results from before the current sweep, restored if it is aborted
  logic [CODE_W-1:0]   tt_bak;
  logic                match_bak;
  logic                dout_s;

  logic abort_act;
  logic accept;
  logic do_sample;
  logic finish;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.dut_out),
    .q     (dout_s)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: abort overrides every transition out of a non-idle state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)          state_nxt = APPLY;
      APPLY:   if (cnt == 8'd0)     state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == IDX_LAST) ? DONE : APPLY;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_act) state_nxt = IDLE;
  end

  // control strobes decoded from state; done_q high means we are in the
  // cycle right after DONE, where a start must not be taken
  always_comb begin
    abort_act = bus.abort && (state != IDLE);
    accept    = (state == IDLE) && bus.start && !bus.abort && !done_q;
    do_sample = (state == SAMPLE) && !abort_act;
    finish    = (state == DONE) && !abort_act;
  end

  // datapath: settle counter, index, stimulus and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      cnt       <= 8'd0;
      dut_in_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tt_code_q <= '0;
      match_q   <= 1'b0;
      exp_q     <= '0;
      tt_bak    <= '0;
      match_bak <= 1'b0;
    end else if (abort_act) begin
      idx       <= '0;
      cnt       <= 8'd0;
      dut_in_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tt_code_q <= tt_bak;
      match_q   <= match_bak;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        exp_q     <= bus.expect_code;
        tt_bak    <= tt_code_q;
        match_bak <= match_q;
        match_q   <= 1'b0;
        idx       <= '0;
        dut_in_q  <= '0;
        busy_q    <= 1'b1;
        cnt       <= CNT_LOAD;
      end
      if (state == APPLY && cnt != 8'd0) cnt <= cnt - 8'd1;
      if (do_sample) begin
        tt_code_q[IDX_LAST - idx] <= dout_s;
        if (idx != IDX_LAST) begin
          idx      <= idx + N_INPUTS'(1);
          dut_in_q <= idx + N_INPUTS'(1);
          cnt      <= CNT_LOAD;
        end
      end
      if (finish) begin
        done_q   <= 1'b1;
        busy_q   <= 1'b0;
        match_q  <= (tt_code_q == exp_q);
        dut_in_q <= '0;
        idx      <= '0;
      end
    end
  end

  assign bus.dut_in  = dut_in_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.tt_code = tt_code_q;
  assign bus.match   = match_q;

endmodule

// File: tb/tb_tt_extract.sv
// Directed bench for tt_extract: sweeps against modelled gates, abort,
// ignored starts, back-to-back sweeps and asynchronous reset.
module tb_tt_extract;

  localparam int SETTLE_TB = 4;
  localparam int LAT       = 8 * (SETTLE_TB + 1) + 1;

  logic clk;
  logic rst_n;
  int   mode;
  int   n_assert;
  int   n_fail;

  tt_extract_if bus ();

  tt_extract #(.SETTLE(SETTLE_TB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gate models: 0 = NOT(in1 AND (in2 OR in3)), 1 = tied 0, 2 = parity
  assign bus.dut_out = (mode == 0) ? ~(bus.dut_in[2] & (bus.dut_in[1] | bus.dut_in[0])) :
                       (mode == 1) ? 1'b0 :
                       ^bus.dut_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // one sweep; tail = cycles watched after the done pulse
  task automatic sweep(input logic [7:0] expc, input int m, input bit spam, input int tail,
                       output int lat, output int oerr, output int ndone, output int late);
    mode = m;
    bus.expect_code = expc;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("accept_busy", {31'd0, bus.busy}, 32'd1);
    chk("accept_match_clr", {31'd0, bus.match}, 32'd0);
    lat = -1; oerr = 0; ndone = 0; late = 0;
    for (int k = 0; k < 200 && lat < 0; k++) begin
      if (bus.done === 1'b1) begin
        lat = k;
        ndone++;
      end else begin
        if (k < LAT - 1 && bus.dut_in !== 3'(k / (SETTLE_TB + 1))) oerr++;
        bus.start = spam && (k % 6 == 2);
        @(posedge clk);
        #1;
      end
    end
    bus.start = spam;
    for (int j = 0; j < tail; j++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) ndone++;
      if (bus.busy === 1'b1) late++;
    end
  endtask

  int lat, oerr, ndone, late;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    mode     = 0;
    rst_n    = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.expect_code = 8'h00;

    repeat (2) @(negedge clk);
    chk("rst_dut_in", {29'd0, bus.dut_in}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_tt_code", {24'd0, bus.tt_code}, 32'd0);
    chk("rst_match", {31'd0, bus.match}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // sweep A: NOT(in1 AND (in2 OR in3)) -> F8
    sweep(8'hF8, 0, 1'b0, 1, lat, oerr, ndone, late);
    chk("A_latency", lat, LAT);
    chk("A_tt_code", {24'd0, bus.tt_code}, 32'hF8);
    chk("A_match", {31'd0, bus.match}, 32'd1);
    chk("A_order", oerr, 0);
    chk("A_ndone", ndone, 1);

    // sweep B started the cycle after A's done: tied 0, expect FF
    sweep(8'hFF, 1, 1'b0, 3, lat, oerr, ndone, late);
    chk("B_latency", lat, LAT);
    chk("B_tt_code", {24'd0, bus.tt_code}, 32'h00);
    chk("B_match", {31'd0, bus.match}, 32'd0);
    chk("B_order", oerr, 0);

    // sweep C: parity gate, start pulses while busy and coincident with done
    sweep(8'h69, 2, 1'b1, 10, lat, oerr, ndone, late);
    chk("C_latency", lat, LAT);
    chk("C_tt_code", {24'd0, bus.tt_code}, 32'h69);
    chk("C_match", {31'd0, bus.match}, 32'd1);
    chk("C_ndone", ndone, 1);
    chk("C_busy_after", late, 0);

    // abort during idx=3 APPLY
    mode = 0;
    bus.expect_code = 8'hF8;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    chk("abort_pre_idx", {29'd0, bus.dut_in}, 32'd3);
    chk("abort_pre_match", {31'd0, bus.match}, 32'd0);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_dut_in", {29'd0, bus.dut_in}, 32'd0);
    chk("abort_tt_code", {24'd0, bus.tt_code}, 32'h69);
    chk("abort_match", {31'd0, bus.match}, 32'd1);
    ndone = 0; late = 0;
    for (int j = 0; j < 60; j++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) ndone++;
      if (bus.busy === 1'b1) late++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_stays_idle", late, 0);

    // abort together with start in IDLE
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_start_idle", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_start_dut_in", {29'd0, bus.dut_in}, 32'd0);

    // asynchronous reset while in SAMPLE of combination 0
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_tt_code", {24'd0, bus.tt_code}, 32'd0);
    chk("mid_rst_match", {31'd0, bus.match}, 32'd0);
    chk("mid_rst_dut_in", {29'd0, bus.dut_in}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // recovery sweep after reset
    sweep(8'hF8, 0, 1'b0, 2, lat, oerr, ndone, late);
    chk("R_latency", lat, LAT);
    chk("R_tt_code", {24'd0, bus.tt_code}, 32'hF8);
    chk("R_match", {31'd0, bus.match}, 32'd1);
    chk("R_order", oerr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
